keypad: RTL
===========

# keypad

Memory-mapped 4x4 matrix keypad scanner: the input-side counterpart of the 7-segment display peripheral, using the same `address`/`dataIn`/`load`/`dataOut` bus. It drives keypad rows and samples columns with the two-flop synchronizer described under Operation. Each key is debounced, and one 4-bit key code per press is queued in a 4-deep FIFO. The CPU reads the head and pops it by writing.

## Interface
- `SCAN_DIV`, 1000: clocks per row slot; must be ≥ 4.
- `DEBOUNCE`, 4: consecutive identical frames needed to accept a press or a release; must be ≥ 2.
- `CLK`  in  1  system clock, all state on posedge.
- `RST`  in  1  reset, asynchronous and active-high.
- `address`  in  2  register select.
- `dataIn`  in  16  write data.
- `load`  in  1  write strobe for `address`.
- `ROW`  out  4  row drive, active-low, registered; exactly one bit low while enabled.
- `COL`  in  4  column sense, active-low (external pull-ups), asynchronous.
- `dataOut`  out  16  combinational read of the register at `address`.

## Operation
- Register map:
  - 0 read: {bit15 `nonempty`, bits 14:12 `count` (0–4), bits 3:0 head code, other bits 0}. Head code is 0 when empty.
  - 0 write: pop the head; `dataIn` is ignored; a pop of an empty FIFO is a no-op.
  - 1 read: status {bit0 `held` (FSM in HELD), bit1 `overflow` sticky, bits 7:4 candidate/held code, other bits 0}.
  - 1 write: `dataIn[1]`=1 clears `overflow`.
  - 2 read/write: control; bit0 `enable`, reset value 1; other bits read 0.
  - 3: reads 0; writes are ignored.
- Scan:
  - Row index `r` (0..3) advances every `SCAN_DIV` clocks; `ROW = ~(1<<r)`.
  - `COL` passes through a 2-flop synchronizer and is sampled on the last clock of each row slot.
  - A frame is 4 slots. At the end of the row-3 slot, the frame result is evaluated.
  - The frame result is the pressed key with the lowest `r*4+col` (lowest row first, then lowest column), or "none".
- FSM, evaluated once per frame end:
  - IDLE: a key K is seen → DEBOUNCE, candidate=K, cnt=1.
  - DEBOUNCE, same K seen: cnt++. When cnt reaches `DEBOUNCE`, push K and go to HELD.
  - DEBOUNCE, a different key or none is seen: go to IDLE.
  - HELD: while K is seen, stay. Any other result (none or a different key) → RELEASE, cnt=1.
  - RELEASE: "none" seen → cnt++, and when cnt reaches `DEBOUNCE` go to IDLE. Any key seen → cnt=1 and stay in RELEASE.
  - Exactly one push per accepted press; holding a key never auto-repeats.
- FIFO:
  - A push while full is dropped and sets `overflow`; FIFO contents are unchanged.
  - Push and pop in the same cycle: the pop takes the old head and the push is accepted, even when full. `overflow` is not set.
  - A clear write and an overflow in the same cycle: set wins.
- Disable (`enable`=0):
  - `ROW`=4'b1111; FSM → IDLE; scan counters are held at 0.
  - FIFO and `overflow` are retained; pops still work.
  - Re-enable restarts scanning at row 0, at the start of a slot.

## Timing
- Reset values: `ROW`=4'b1110. FIFO empty, `count`=0, `overflow`=0, `enable`=1, FSM IDLE, counters 0.
- `dataOut` at reset by address: 0 → 16'h0000, 1 → 16'h0000, 2 → 16'h0001, 3 → 16'h0000.
- Register writes take effect on the `CLK` edge where `load`=1. `dataOut` reflects the new value in the following cycle.
- Push latency: a key stable from frame 1 is pushed on the clock of the frame-`DEBOUNCE` end edge, i.e. `4*SCAN_DIV*DEBOUNCE` clocks after scanning of frame 1 began. The `nonempty` flag is visible on the next cycle.
- `RST` mid-scan or mid-debounce: all state returns immediately to the reset values; any pending candidate is discarded.

## Structure
- Package `keypad_pkg` holds:
  - register address constants;
  - bit positions of status and control fields;
  - the FSM state enum {IDLE, DEBOUNCE, HELD, RELEASE};
  - FIFO depth 4.
- Sub-module `keypad_fifo`: 4x4-bit FIFO with push/pop/full/empty/count and simultaneous push-pop. The scanner, FSM and register decode live in `keypad`.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE`=2 (frame = 16 clocks).
- Reset, then idle → `ROW` cycles 1110, 1101, 1011, 0111, each for 4 clocks. `dataOut` at address 0 reads 0x0000 and at address 2 reads 0x0001.
- Hold key r=2, c=1 for 3 frames → after the 2nd frame end, address 0 reads 0x9009. Write to address 0 → reads 0x0000. No second push while the key is held.
- Bounce: key 5 is present in frame 1, absent in frame 2, and present in frames 3–4 → exactly one push, at the frame-4 end.
- Press keys 0, 1, 2, 3, 4 in turn (each followed by a release) without popping → `count`=4 and address 1 bit1=1. Head reads 0x8000+0x4000=0xC000 (code 0). A write of 0x0002 to address 1 clears `overflow`.
- Keys 3 and 6 pressed together → code 3 queued. Write 0 to address 2 → `ROW`=1111 and FSM IDLE. Pops still work.
- Assert `RST` mid-DEBOUNCE → `ROW`=1110 immediately, FIFO empty, and no push occurs afterward while the key stays low.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the memory-mapped 4x4 keypad scanner.
//   - register addresses on the address/dataIn/load/dataOut bus
//   - bit positions of the read-back fields
//   - key FSM state encoding
//   - key FIFO geometry
//   - lowest_col(): lowest-numbered pressed column of an active-high column mask
package keypad_pkg;

    localparam logic [1:0] ADDR_FIFO   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // Address 0 read-back layout
    localparam int unsigned RD0_NONEMPTY  = 15;
    localparam int unsigned RD0_COUNT_LSB = 12;
    localparam int unsigned RD0_CODE_LSB  = 0;

    // Address 1 status layout
    localparam int unsigned STAT_HELD     = 0;
    localparam int unsigned STAT_OVF      = 1;
    localparam int unsigned STAT_CODE_LSB = 4;

    // Address 2 control layout
    localparam int unsigned CTRL_EN = 0;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = 2;
    localparam int unsigned FIFO_CW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kp_state_t;

    function automatic logic [1:0] lowest_col(input logic [3:0] pressed);
        if (pressed[0])      return 2'd0;
        else if (pressed[1]) return 2'd1;
        else if (pressed[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: 4-entry x 4-bit key-code FIFO.
//   CLK, RST : clock, asynchronous active-high reset
//   push/din : enqueue din (dropped when full unless a pop happens in the same cycle)
//   pop      : dequeue head (no-op when empty)
//   head     : entry at the read pointer (meaningless when empty)
//   count    : number of stored entries, 0..4
//   full/empty
//   dropped  : pulses when a push was refused
module keypad_fifo
    import keypad_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               push,
    input  logic               pop,
    input  logic [3:0]         din,
    output logic [3:0]         head,
    output logic [FIFO_CW-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               dropped
);

    logic [3:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_q;
    logic [FIFO_AW-1:0] wr_q;
    logic [FIFO_CW-1:0] count_q;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == FIFO_CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_q];

    // A pop frees the slot in the same cycle, so a push is still accepted
    // when full; with wr_q == rd_q the new code overwrites the departing head.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dropped = push && !do_push;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_q] <= din;
                wr_q      <= wr_q + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + FIFO_CW'(1);
                2'b01:   count_q <= count_q - FIFO_CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad.sv
// keypad: memory-mapped 4x4 matrix keypad scanner with per-key debounce
// and a 4-deep key-code FIFO.
//   CLK     : system clock
//   RST     : asynchronous active-high reset
//   address : register select (0 fifo, 1 status, 2 control, 3 reserved)
//   dataIn  : write data
//   load    : write strobe
//   ROW     : active-low row drive, one row low per slot while enabled
//   COL     : active-low column sense, asynchronous to CLK
//   dataOut : combinational read of the register at address
// Parameters: SCAN_DIV clocks per row slot (>= 4), DEBOUNCE frames (>= 2).
module keypad
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  address,
    input  logic [15:0] dataIn,
    input  logic        load,
    output logic [3:0]  ROW,
    input  logic [3:0]  COL,
    output logic [15:0] dataOut
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);

    // Scanner state
    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [DW-1:0] div_q;
    logic [1:0]    r_q;
    logic [3:0]    row_q;
    logic          acc_found;
    logic [3:0]    acc_code;
    logic          enable_q;
    logic          overflow_q;

    // FSM state
    kp_state_t     state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;

    // Decode / datapath
    logic          wr_fifo, wr_stat, wr_ctrl;
    logic          enable_d;
    logic          slot_end, frame_end;
    logic          slot_hit;
    logic [3:0]    slot_code;
    logic          res_found;
    logic [3:0]    res_code;
    logic [1:0]    r_d;
    logic [3:0]    row_d;
    logic          same_key;

    // FIFO
    logic [3:0]         fifo_head;
    logic [FIFO_CW-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_dropped;

    logic unused_inputs;
    assign unused_inputs = ^{dataIn[15:2], fifo_full};

    assign ROW = row_q;

    always_comb begin
        wr_fifo  = load && (address == ADDR_FIFO);
        wr_stat  = load && (address == ADDR_STATUS);
        wr_ctrl  = load && (address == ADDR_CTRL);
        enable_d = wr_ctrl ? dataIn[CTRL_EN] : enable_q;

        slot_end  = enable_q && (div_q == DIV_LAST);
        frame_end = slot_end && (r_q == 2'd3);
        slot_hit  = |(~col_s2);
        slot_code = {r_q, lowest_col(~col_s2)};

        // Rows are visited in ascending order, so the first hit of the frame
        // is already the lowest r*4+col; the row-3 sample joins at frame end.
        res_found = acc_found || slot_hit;
        res_code  = acc_found ? acc_code : slot_code;
        same_key  = res_found && (res_code == cand_q);

        // ROW is registered, so it is built from the next row index and the
        // next enable; re-enabling lands on row 0 in the same edge.
        if (!enable_q)     r_d = 2'd0;
        else if (slot_end) r_d = r_q + 2'd1;
        else               r_d = r_q;
        row_d = enable_d ? ~(4'b0001 << r_d) : 4'b1111;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_s1     <= '1;
            col_s2     <= '1;
            div_q      <= '0;
            r_q        <= '0;
            row_q      <= 4'b1110;
            acc_found  <= 1'b0;
            acc_code   <= '0;
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            col_s1   <= COL;
            col_s2   <= col_s1;
            enable_q <= enable_d;
            row_q    <= row_d;

            if (!enable_q) begin
                div_q     <= '0;
                r_q       <= '0;
                acc_found <= 1'b0;
                acc_code  <= '0;
            end else if (slot_end) begin
                div_q <= '0;
                r_q   <= r_d;
                if (frame_end) begin
                    acc_found <= 1'b0;
                    acc_code  <= '0;
                end else if (!acc_found && slot_hit) begin
                    acc_found <= 1'b1;
                    acc_code  <= slot_code;
                end
            end else begin
                div_q <= div_q + DW'(1);
            end

            // A refused push in the same cycle as a clear keeps the flag set.
            if (fifo_dropped) begin
                overflow_q <= 1'b1;
            end else if (wr_stat && dataIn[STAT_OVF]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        if (!enable_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_found) begin
                        state_d = ST_DEBOUNCE;
                        cand_d  = res_code;
                        cnt_d   = CW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (same_key) begin
                        if (cnt_q + CW'(1) == CNT_DONE) begin
                            push    = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (!same_key) begin
                        state_d = ST_RELEASE;
                        cnt_d   = CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (res_found) begin
                        cnt_d = CW'(1);
                    end else if (cnt_q + CW'(1) == CNT_DONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    keypad_fifo u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .pop     (wr_fifo),
        .din     (cand_q),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    always_comb begin
        dataOut = '0;
        case (address)
            ADDR_FIFO: begin
                dataOut[RD0_NONEMPTY]               = !fifo_empty;
                dataOut[RD0_COUNT_LSB +: FIFO_CW]   = fifo_count;
                dataOut[RD0_CODE_LSB +: 4]          = fifo_empty ? 4'h0 : fifo_head;
            end
            ADDR_STATUS: begin
                dataOut[STAT_HELD]          = (state_q == ST_HELD);
                dataOut[STAT_OVF]           = overflow_q;
                dataOut[STAT_CODE_LSB +: 4] = (state_q == ST_IDLE) ? 4'h0 : cand_q;
            end
            ADDR_CTRL: begin
                dataOut[CTRL_EN] = enable_q;
            end
            default: dataOut = '0;
        endcase
    end

endmodule
